// File: rtl/sr_crypto_unit.sv
// sr_crypto_unit: multi-cycle SHA-256 / SHA-512 (RV32 Zknh) responder.
// One request is accepted over valid/ready and computed for LATENCY cycles.
// The result and destination tag are then held until the core takes them.
// kill aborts any in-flight or held operation, and no response is produced for it.

module sr_crypto_unit #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // BUSY counts down from this value, so the BUSY phase lasts LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  op_r;
  logic [31:0] rs1_r;
  logic [31:0] rs2_r;
  logic [4:0]  rd_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;
  logic [4:0]  rsp_rd_r;
  logic        rsp_err_r;
  logic        accept_s;
  logic        finish_s;
  logic [32:0] result_s;

  // Rotate right by a constant amount. The operand is duplicated so that
  // bits shifted out at the bottom come back in at the top.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl_s;
    dbl_s = {x, x} >> amt;
    return dbl_s[31:0];
  endfunction

  // Result function. Bit 32 is the illegal-op flag, and bits 31:0 are the data.
  // For ops 5 and 7, the low-half variants add one more rs2 term to the
  // matching high-half expression.
  function automatic logic [32:0] sha_compute(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] sig0h_s;
    logic [31:0] sig1h_s;
    logic [32:0] res_s;
    sig0h_s = (a >> 5'd1) ^ (a >> 5'd7) ^ (a >> 5'd8) ^ (b << 5'd31) ^ (b << 5'd24);
    sig1h_s = (a << 5'd3) ^ (a >> 5'd6) ^ (a >> 5'd19) ^ (b >> 5'd29) ^ (b << 5'd13);
    case (op)
      4'd0:    res_s = {1'b0, ror32(a, 5'd7) ^ ror32(a, 5'd18) ^ (a >> 5'd3)};
      4'd1:    res_s = {1'b0, ror32(a, 5'd17) ^ ror32(a, 5'd19) ^ (a >> 5'd10)};
      4'd2:    res_s = {1'b0, ror32(a, 5'd2) ^ ror32(a, 5'd13) ^ ror32(a, 5'd22)};
      4'd3:    res_s = {1'b0, ror32(a, 5'd6) ^ ror32(a, 5'd11) ^ ror32(a, 5'd25)};
      4'd4:    res_s = {1'b0, sig0h_s};
      4'd5:    res_s = {1'b0, sig0h_s ^ (b << 5'd25)};
      4'd6:    res_s = {1'b0, sig1h_s};
      4'd7:    res_s = {1'b0, sig1h_s ^ (b << 5'd26)};
      4'd8:    res_s = {1'b0, (a << 5'd25) ^ (a << 5'd30) ^ (a >> 5'd28) ^
                              (b >> 5'd7) ^ (b >> 5'd2) ^ (b << 5'd4)};
      4'd9:    res_s = {1'b0, (a << 5'd23) ^ (a >> 5'd14) ^ (a >> 5'd18) ^
                              (b >> 5'd9) ^ (b << 5'd18) ^ (b << 5'd14)};
      default: res_s = {1'b1, 32'h0000_0000};
    endcase
    return res_s;
  endfunction

  // The result is computed from the latched operands, so request inputs
  // may change freely while BUSY.
  assign result_s = sha_compute(op_r, rs1_r, rs2_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. kill has priority over acceptance and over the response handshake.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    if (kill) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            state_nxt_s = ST_BUSY;
            accept_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 4'd0) begin
            state_nxt_s = ST_DONE;
            finish_s    = 1'b1;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Latch operands on acceptance. They are held through BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 4'd0;
      rs1_r <= 32'h0000_0000;
      rs2_r <= 32'h0000_0000;
      rd_r  <= 5'd0;
    end else if (accept_s) begin
      op_r  <= req_op;
      rs1_r <= req_rs1;
      rs2_r <= req_rs2;
      rd_r  <= req_rd;
    end
  end

  // Latency counter. It is loaded on accept and decremented in BUSY.
  // It stops at zero because BUSY is exited at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == ST_BUSY) && !kill && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Response registers. Data, tag and error are captured on entry to DONE.
  // They are left untouched afterwards, including on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r <= 32'h0000_0000;
      rsp_rd_r   <= 5'd0;
      rsp_err_r  <= 1'b0;
    end else if (finish_s) begin
      rsp_data_r <= result_s[31:0];
      rsp_rd_r   <= rd_r;
      rsp_err_r  <= result_s[32];
    end
  end

  // Registered response-valid flag. It is high exactly while the FSM sits in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_rd    = rsp_rd_r;
  assign rsp_err   = rsp_err_r;

endmodule
